windowed_register_file: RTL and testbench
=========================================

WINDOWED_REGISTER_FILE -- requirements
Module: windowed_register_file

Interface
REQ-001 Parameter DATA_W, default 32, sets the width of every data port and physical register.
REQ-002 Parameter NWINDOWS, default 8, legal 2..32, sets the number of register windows; CW = $clog2(NWINDOWS).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RA, RB, RD  input  5 each  logical read selects for ports A, B, D.
REQ-006 PA, PB, PD  output  DATA_W each  read data for RA, RB, RD.
REQ-007 RW  input  5  logical write select; PW  input  DATA_W  write data; LE  input  1  write enable.
REQ-008 save, restore  input  1 each  window-rotate requests.
REQ-009 WIM  input  NWINDOWS  window-invalid mask, one bit per window.
REQ-010 cwp  output  CW  current window pointer.
REQ-011 trap_ovf, trap_unf  output  1 each  one-cycle window overflow / underflow trap pulses.

Function
REQ-012 Physical storage shall be 8 globals plus 16*NWINDOWS windowed registers; index map for window w: r0-r7 -> g[r]; r8-r15 -> 8+16w+(r-8); r16-r23 -> 16+16w+(r-16); r24-r31 -> 8+16*((w+1) mod NWINDOWS)+(r-24).
REQ-013 Reads shall be combinational (zero latency), mapped through the current cwp, and all three ports shall be independent, including identical selects.
REQ-014 Logical r0 shall always read 0; writes to RW=0 shall be discarded.
REQ-015 With LE=1 at a rising edge, PW shall be written to the physical register mapped from RW using the pre-edge cwp; LE=0 leaves storage unchanged.
REQ-016 save alone: if WIM[(cwp-1) mod NWINDOWS]=0 then cwp <= (cwp-1) mod NWINDOWS, else cwp unchanged and trap_ovf=1 for the next cycle.
REQ-017 restore alone: if WIM[(cwp+1) mod NWINDOWS]=0 then cwp <= (cwp+1) mod NWINDOWS, else cwp unchanged and trap_unf=1 for the next cycle.
REQ-018 cwp shall wrap: save at cwp=0 targets NWINDOWS-1; restore at NWINDOWS-1 targets 0.
REQ-019 save and restore asserted together shall be ignored: no cwp change, no trap.
REQ-020 A write and a save/restore in the same cycle shall both take effect; the write uses the old window.
REQ-021 trap_ovf and trap_unf shall be registered, high for exactly one cycle per trapping request, and never high together.
REQ-022 Without bypass, a read of the register being written returns the old value until after the edge.

Reset
REQ-023 reset=1 at a rising edge shall set cwp=0, trap_ovf=0, trap_unf=0, and clear every physical register to 0.
REQ-024 reset shall take priority over LE, save and restore in the same cycle; a pending trap pulse is cancelled.

Configuration
REQ-025 Macro WRF_BYPASS_EN defined: when LE=1, RW!=0 and a read select maps to the same physical register as RW, that port shall output PW combinationally.
REQ-026 WRF_BYPASS_EN undefined: no forwarding; behaviour per REQ-022.

Structure
REQ-027 A shared package shall hold NUM_GLOBALS=8, REGS_PER_WINDOW=16, the physical-count function (8+16*NWINDOWS) and the logical-to-physical index function.
REQ-028 One sub-module, wrf_index_map (logical reg + cwp -> physical index), shall be instantiated four times, for RA, RB, RD and RW.

Verification
REQ-029 Reset, then write r9=32'hA5A5_0001 at cwp=0; save -> cwp=7, r25 reads 32'hA5A5_0001, r9 reads 0.
REQ-030 Write r3=32'h1234 at cwp=0; save and restore -> r3 reads 32'h1234 in both windows; RW=0 with PW=32'hFFFF_FFFF -> PA with RA=0 reads 0.
REQ-031 WIM=8'b1000_0000, cwp=0, save -> cwp stays 0, trap_ovf=1 for one cycle; WIM=0, save -> cwp=7; restore -> cwp=0.
REQ-032 save and restore together at cwp=3 -> cwp stays 3, no trap; LE=1 RW=16 PW=5 with save -> old window r16=5 after restore.
REQ-033 Same-cycle LE=1 RW=RA=10 PW=32'hDEAD_BEEF -> PA=32'hDEAD_BEEF before the edge with WRF_BYPASS_EN, old value without it.
REQ-034 reset asserted alongside save at cwp=5 -> cwp=0, traps 0, all registers 0.

Source files
------------

// File: rtl/windowed_register_file_pkg.sv
// -----------------------------------------------------------------------------
// windowed_register_file_pkg
// Shared constants and helpers for the windowed register file.
//   NUM_GLOBALS      : globals g0..g7, visible as r0..r7 in every window
//   REGS_PER_WINDOW  : physical registers owned by each window (locals + outs)
//   win_op_e         : window-rotate operation selected in a cycle
//   phys_count()     : total physical registers for a given window count
//   phys_index()     : logical register + window -> physical register index
//   decode_win_op()  : save/restore request pair -> window operation
// -----------------------------------------------------------------------------
package windowed_register_file_pkg;

  localparam int unsigned NUM_GLOBALS     = 8;
  localparam int unsigned REGS_PER_WINDOW = 16;

  typedef enum logic [1:0] {
    WIN_HOLD    = 2'd0,
    WIN_SAVE    = 2'd1,
    WIN_RESTORE = 2'd2
  } win_op_e;

  function automatic int unsigned phys_count(input int unsigned nwindows);
    return NUM_GLOBALS + REGS_PER_WINDOW * nwindows;
  endfunction

  // Window w owns physical slots 8+16w .. 8+16w+15: its outs (r8-r15) come
  // first, then its locals (r16-r23). Its ins (r24-r31) are the outs of
  // window w+1, which is how a caller's outs become the callee's ins.
  function automatic int unsigned phys_index(input int unsigned lreg,
                                             input int unsigned win,
                                             input int unsigned nwindows);
    int unsigned next_win;
    int unsigned idx;
    next_win = (win + 32'd1 == nwindows) ? 32'd0 : win + 32'd1;
    if (lreg < 32'd8) begin
      idx = lreg;
    end else if (lreg < 32'd24) begin
      idx = NUM_GLOBALS + REGS_PER_WINDOW * win + (lreg - 32'd8);
    end else begin
      idx = NUM_GLOBALS + REGS_PER_WINDOW * next_win + (lreg - 32'd24);
    end
    return idx;
  endfunction

  // Simultaneous save and restore cancel each other out.
  function automatic win_op_e decode_win_op(input logic save, input logic restore);
    win_op_e op;
    if (save && !restore) begin
      op = WIN_SAVE;
    end else if (restore && !save) begin
      op = WIN_RESTORE;
    end else begin
      op = WIN_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/windowed_register_file_index_map.sv
// -----------------------------------------------------------------------------
// wrf_index_map
// Combinational translation of a logical register select into a physical
// register index for the given window pointer.
// Ports:
//   lreg_i [4:0]      logical register r0..r31
//   cwp_i  [CW-1:0]   window pointer used for the translation
//   pidx_o [IDX_W-1:0] physical register index
// -----------------------------------------------------------------------------
module wrf_index_map
  import windowed_register_file_pkg::*;
#(
  parameter int NWINDOWS = 8,
  parameter int CW       = $clog2(NWINDOWS),
  parameter int IDX_W    = $clog2(phys_count(NWINDOWS))
) (
  input  logic [4:0]       lreg_i,
  input  logic [CW-1:0]    cwp_i,
  output logic [IDX_W-1:0] pidx_o
);

  assign pidx_o = IDX_W'(phys_index(32'(lreg_i), 32'(cwp_i), NWINDOWS));

endmodule

// File: rtl/windowed_register_file.sv
// -----------------------------------------------------------------------------
// windowed_register_file
// SPARC-style windowed register file: 8 globals plus 16 registers per window,
// three combinational read ports, one write port, save/restore window rotation
// guarded by a window-invalid mask with registered overflow/underflow traps.
//
// Optional feature: define WRF_BYPASS_EN to forward the write data (PW) to any
// read port whose select maps to the physical register being written.
//
// Ports:
//   clk                 clock, all state on rising edge
//   reset               synchronous active-high reset (clears every register)
//   RA, RB, RD [4:0]    logical read selects
//   PA, PB, PD          read data for RA, RB, RD (r0 always reads 0)
//   RW [4:0], PW, LE    write select, write data, write enable
//   save, restore       window rotate requests
//   WIM [NWINDOWS-1:0]  window-invalid mask
//   cwp [CW-1:0]        current window pointer
//   trap_ovf, trap_unf  one-cycle trap pulses for rejected save / restore
// -----------------------------------------------------------------------------
module windowed_register_file
  import windowed_register_file_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NWINDOWS = 8,
  localparam int CW       = $clog2(NWINDOWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          RA,
  input  logic [4:0]          RB,
  input  logic [4:0]          RD,
  output logic [DATA_W-1:0]   PA,
  output logic [DATA_W-1:0]   PB,
  output logic [DATA_W-1:0]   PD,
  input  logic [4:0]          RW,
  input  logic [DATA_W-1:0]   PW,
  input  logic                LE,
  input  logic                save,
  input  logic                restore,
  input  logic [NWINDOWS-1:0] WIM,
  output logic [CW-1:0]       cwp,
  output logic                trap_ovf,
  output logic                trap_unf
);

  localparam int PHYS_N = phys_count(NWINDOWS);
  localparam int IDX_W  = $clog2(PHYS_N);
  localparam int NRD    = 3;

  logic [DATA_W-1:0] regs_q [PHYS_N];
  logic [CW-1:0]     cwp_q, cwp_d;
  logic              trap_ovf_q, trap_ovf_d;
  logic              trap_unf_q, trap_unf_d;

  logic [CW-1:0]     cwp_dec, cwp_inc;
  win_op_e           win_op;

  logic [4:0]        rd_sel  [NRD];
  logic [IDX_W-1:0]  rd_idx  [NRD];
  logic [DATA_W-1:0] rd_data [NRD];
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_en;

  // ---------------------------------------------------------------------------
  // Logical -> physical translation, all through the pre-edge window pointer
  // ---------------------------------------------------------------------------
  assign rd_sel[0] = RA;
  assign rd_sel[1] = RB;
  assign rd_sel[2] = RD;

  wrf_index_map #(.NWINDOWS(NWINDOWS), .CW(CW), .IDX_W(IDX_W)) u_map_a (
    .lreg_i (RA),
    .cwp_i  (cwp_q),
    .pidx_o (rd_idx[0])
  );

  wrf_index_map #(.NWINDOWS(NWINDOWS), .CW(CW), .IDX_W(IDX_W)) u_map_b (
    .lreg_i (RB),
    .cwp_i  (cwp_q),
    .pidx_o (rd_idx[1])
  );

  wrf_index_map #(.NWINDOWS(NWINDOWS), .CW(CW), .IDX_W(IDX_W)) u_map_d (
    .lreg_i (RD),
    .cwp_i  (cwp_q),
    .pidx_o (rd_idx[2])
  );

  wrf_index_map #(.NWINDOWS(NWINDOWS), .CW(CW), .IDX_W(IDX_W)) u_map_w (
    .lreg_i (RW),
    .cwp_i  (cwp_q),
    .pidx_o (wr_idx)
  );

  // r0 is hardwired to zero, so a write to it never reaches storage.
  assign wr_en = LE && (RW != 5'd0);

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      // NOTE: every output of a combinational block is given a value on every
      // path before any conditional override; otherwise a latch is inferred.
      rd_data[p] = (rd_sel[p] == 5'd0) ? '0 : regs_q[rd_idx[p]];
`ifdef WRF_BYPASS_EN
      if (wr_en && (rd_sel[p] != 5'd0) && (rd_idx[p] == wr_idx)) begin
        rd_data[p] = PW;
      end
`endif
    end
  end

  assign PA = rd_data[0];
  assign PB = rd_data[1];
  assign PD = rd_data[2];

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: clearing every entry on reset costs a reset net per flop and
      // rules out RAM macros; it is done here because software relies on a
      // zeroed register file after reset.
      for (int i = 0; i < PHYS_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of statement order.
      regs_q[wr_idx] <= PW;
    end
  end

  // ---------------------------------------------------------------------------
  // Window pointer and traps
  // ---------------------------------------------------------------------------
  // Neighbouring windows with modulo-NWINDOWS wrap; NWINDOWS need not be a
  // power of two, so the wrap is explicit rather than relying on overflow.
  assign cwp_dec = (cwp_q == '0) ? CW'(NWINDOWS - 1) : cwp_q - CW'(1);
  assign cwp_inc = (cwp_q == CW'(NWINDOWS - 1)) ? '0 : cwp_q + CW'(1);
  assign win_op  = decode_win_op(save, restore);

  always_comb begin
    cwp_d      = cwp_q;
    trap_ovf_d = 1'b0;
    trap_unf_d = 1'b0;
    case (win_op)
      WIN_SAVE: begin
        if (WIM[cwp_dec]) trap_ovf_d = 1'b1;
        else              cwp_d      = cwp_dec;
      end
      WIN_RESTORE: begin
        if (WIM[cwp_inc]) trap_unf_d = 1'b1;
        else              cwp_d      = cwp_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cwp_q      <= '0;
      trap_ovf_q <= 1'b0;
      trap_unf_q <= 1'b0;
    end else begin
      cwp_q      <= cwp_d;
      trap_ovf_q <= trap_ovf_d;
      trap_unf_q <= trap_unf_d;
    end
  end

  assign cwp      = cwp_q;
  assign trap_ovf = trap_ovf_q;
  assign trap_unf = trap_unf_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// -----------------------------------------------------------------------------
// tb_windowed_register_file
// Self-checking bench for windowed_register_file (DATA_W=32, NWINDOWS=8).
// Directed vector table, hand-written corner sequences, then randomized
// traffic against a window-level behavioural model.
// -----------------------------------------------------------------------------
module tb_windowed_register_file;

  localparam int N  = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    RA, RB, RD, RW;
  logic [DW-1:0] PA, PB, PD, PW;
  logic          LE, save, restore;
  logic [N-1:0]  WIM;
  logic [2:0]    cwp;
  logic          trap_ovf, trap_unf;

  int checks = 0;
  int errors = 0;

  windowed_register_file #(.DATA_W(DW), .NWINDOWS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .RA       (RA),
    .RB       (RB),
    .RD       (RD),
    .PA       (PA),
    .PB       (PB),
    .PD       (PD),
    .RW       (RW),
    .PW       (PW),
    .LE       (LE),
    .save     (save),
    .restore  (restore),
    .WIM      (WIM),
    .cwp      (cwp),
    .trap_ovf (trap_ovf),
    .trap_unf (trap_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: globals, and per window an "outs" block (r8-r15) and a
  // "locals" block (r16-r23). A window's ins are its successor's outs.
  // ---------------------------------------------------------------------------
  logic [31:0] m_glob [8];
  logic [31:0] m_outs [N][8];
  logic [31:0] m_locs [N][8];
  int          m_cwp;
  logic        m_ovf, m_unf;

  function automatic void m_clear();
    for (int i = 0; i < 8; i++) begin
      m_glob[i] = '0;
      for (int w = 0; w < N; w++) begin
        m_outs[w][i] = '0;
        m_locs[w][i] = '0;
      end
    end
    m_cwp = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int w, input int r);
    if (r == 0)      return '0;
    else if (r < 8)  return m_glob[r];
    else if (r < 16) return m_outs[w][r-8];
    else if (r < 24) return m_locs[w][r-16];
    else             return m_outs[(w+1)%N][r-24];
  endfunction

  function automatic void m_write(input int w, input int r, input logic [31:0] v);
    if (r == 0)      return;
    else if (r < 8)  m_glob[r] = v;
    else if (r < 16) m_outs[w][r-8] = v;
    else if (r < 24) m_locs[w][r-16] = v;
    else             m_outs[(w+1)%N][r-24] = v;
  endfunction

  // Value a read port should show while the current inputs are applied.
  function automatic logic [31:0] m_port(input int r);
    logic [31:0] v;
    v = m_read(m_cwp, r);
`ifdef WRF_BYPASS_EN
    if (LE && RW != 5'd0) begin
      logic [31:0] old;
      old = m_read(m_cwp, int'(RW));
      m_write(m_cwp, int'(RW), PW);
      v = m_read(m_cwp, r);
      m_write(m_cwp, int'(RW), old);
    end
`endif
    return v;
  endfunction

  function automatic void m_step();
    int tgt;
    if (LE) m_write(m_cwp, int'(RW), PW);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (save && !restore) begin
      tgt = (m_cwp + N - 1) % N;
      if (WIM[tgt]) m_ovf = 1'b1; else m_cwp = tgt;
    end else if (restore && !save) begin
      tgt = (m_cwp + 1) % N;
      if (WIM[tgt]) m_unf = 1'b1; else m_cwp = tgt;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        le;
    logic [4:0]  rw;
    logic [31:0] pw;
    logic        sv;
    logic        rs;
    logic [7:0]  wim;
    logic [4:0]  ra, rb, rd;
    int          cwp;
    logic        ovf, unf;
    logic [31:0] pa, pb, pd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic le, input logic [4:0] rw, input logic [31:0] pw,
                              input logic sv, input logic rs, input logic [7:0] wim,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                              input int c, input logic ovf, input logic unf,
                              input logic [31:0] pa, input logic [31:0] pb, input logic [31:0] pd);
    vec_t v;
    v.le = le; v.rw = rw; v.pw = pw; v.sv = sv; v.rs = rs; v.wim = wim;
    v.ra = ra; v.rb = rb; v.rd = rd; v.cwp = c; v.ovf = ovf; v.unf = unf;
    v.pa = pa; v.pb = pb; v.pd = pd;
    return v;
  endfunction

  task automatic idle();
    LE = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; idle(); RW = '0; PW = '0; WIM = '0; RA = '0; RB = '0; RD = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("reset cwp", 32'(cwp), 32'd0);
    check("reset trap_ovf", 32'(trap_ovf), 32'd0);
    check("reset trap_unf", 32'(trap_unf), 32'd0);
    for (int r = 0; r < 32; r++) begin
      RA = 5'(r);
      #1;
      check($sformatf("reset r%0d", r), PA, 32'd0);
    end

    //          le rw  pw             sv rs wim    ra  rb  rd  cwp ovf unf pa            pb            pd
    vecs.push_back(mk(1, 9,  32'hA5A5_0001, 0, 0, 8'h00, 9,  25, 0,  0, 0, 0, 32'hA5A5_0001, 0, 0));
    vecs.push_back(mk(0, 0,  0,             1, 0, 8'h00, 25, 9,  3,  7, 0, 0, 32'hA5A5_0001, 0, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 9,  25, 0,  0, 0, 0, 32'hA5A5_0001, 0, 0));
    vecs.push_back(mk(1, 3,  32'h1234,      0, 0, 8'h00, 3,  9,  0,  0, 0, 0, 32'h1234, 32'hA5A5_0001, 0));
    vecs.push_back(mk(0, 0,  0,             1, 0, 8'h00, 3,  25, 9,  7, 0, 0, 32'h1234, 32'hA5A5_0001, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 3,  9,  0,  0, 0, 0, 32'h1234, 32'hA5A5_0001, 0));
    vecs.push_back(mk(1, 0,  32'hFFFF_FFFF, 0, 0, 8'h00, 0,  3,  9,  0, 0, 0, 0, 32'h1234, 32'hA5A5_0001));
    vecs.push_back(mk(0, 0,  0,             1, 0, 8'h80, 3,  0,  0,  0, 1, 0, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0,  0,             0, 0, 8'h80, 3,  0,  0,  0, 0, 0, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0,  0,             1, 0, 8'h00, 3,  0,  0,  7, 0, 0, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 3,  9,  0,  0, 0, 0, 32'h1234, 32'hA5A5_0001, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 9,  0,  0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 9,  0,  0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 9,  3,  0,  3, 0, 0, 0, 32'h1234, 0));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h10, 3,  0,  0,  3, 0, 1, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0,  0,             0, 0, 8'h10, 3,  0,  0,  3, 0, 0, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0,  0,             1, 1, 8'h00, 3,  0,  0,  3, 0, 0, 32'h1234, 0, 0));
    vecs.push_back(mk(1, 16, 32'd5,         1, 0, 8'h00, 16, 24, 3,  2, 0, 0, 0, 0, 32'h1234));
    vecs.push_back(mk(0, 0,  0,             0, 1, 8'h00, 16, 3,  0,  3, 0, 0, 32'd5, 32'h1234, 0));

    foreach (vecs[i]) begin
      LE = vecs[i].le; RW = vecs[i].rw; PW = vecs[i].pw;
      save = vecs[i].sv; restore = vecs[i].rs; WIM = vecs[i].wim;
      RA = vecs[i].ra; RB = vecs[i].rb; RD = vecs[i].rd;
      tick();
      idle();
      #1;
      check($sformatf("vec%0d cwp", i), 32'(cwp), 32'(vecs[i].cwp));
      check($sformatf("vec%0d trap_ovf", i), 32'(trap_ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d trap_unf", i), 32'(trap_unf), 32'(vecs[i].unf));
      check($sformatf("vec%0d PA", i), PA, vecs[i].pa);
      check($sformatf("vec%0d PB", i), PB, vecs[i].pb);
      check($sformatf("vec%0d PD", i), PD, vecs[i].pd);
    end

    // Same-cycle write and read of r10 at cwp=3: forwarded or old value.
    WIM = '0;
    LE = 1'b1; RW = 5'd10; PW = 32'hDEAD_BEEF; RA = 5'd10; RB = 5'd10; RD = 5'd0;
    #1;
`ifdef WRF_BYPASS_EN
    check("same-cycle PA r10", PA, 32'hDEAD_BEEF);
    check("same-cycle PB r10", PB, 32'hDEAD_BEEF);
`else
    check("same-cycle PA r10", PA, 32'd0);
    check("same-cycle PB r10", PB, 32'd0);
`endif
    check("same-cycle PD r0", PD, 32'd0);
    tick();
    idle();
    #1;
    check("post-write PA r10", PA, 32'hDEAD_BEEF);
    // Outs of window 3 appear as ins of window 2.
    save = 1'b1; RA = 5'd26; RB = 5'd10;
    tick();
    idle();
    #1;
    check("alias cwp", 32'(cwp), 32'd2);
    check("alias r26 w2", PA, 32'hDEAD_BEEF);
    check("alias r10 w2", PB, 32'd0);
    // A write to r0 is never forwarded.
    LE = 1'b1; RW = 5'd0; PW = 32'hFFFF_FFFF; RA = 5'd0;
    #1;
    check("r0 write forward", PA, 32'd0);
    tick();
    idle();

    // Reset priority over save with a trap pending, at cwp=5.
    repeat (3) begin
      restore = 1'b1;
      tick();
    end
    idle();
    LE = 1'b1; RW = 5'd17; PW = 32'd77; RA = 5'd17;
    tick();
    idle();
    #1;
    check("pre-reset cwp", 32'(cwp), 32'd5);
    check("pre-reset r17", PA, 32'd77);
    WIM = 8'h10; save = 1'b1;
    tick();
    #1;
    check("pre-reset trap_ovf", 32'(trap_ovf), 32'd1);
    reset = 1'b1; LE = 1'b1; RW = 5'd17; PW = 32'd99;
    tick();
    reset = 1'b0;
    idle();
    WIM = '0;
    #1;
    check("reset-prio cwp", 32'(cwp), 32'd0);
    check("reset-prio trap_ovf", 32'(trap_ovf), 32'd0);
    check("reset-prio trap_unf", 32'(trap_unf), 32'd0);
    for (int w = 0; w < N; w++) begin
      for (int r = 1; r < 32; r++) begin
        RA = 5'(r);
        #1;
        check($sformatf("reset-prio w%0d r%0d", w, r), PA, 32'd0);
      end
      restore = 1'b1;
      tick();
      idle();
    end
    #1;
    check("scan wrap cwp", 32'(cwp), 32'd0);

    // Randomized traffic against the model.
    m_clear();
    for (int n = 0; n < 1500; n++) begin
      int k;
      LE = ($urandom_range(0, 1) == 1);
      RW = 5'($urandom_range(0, 31));
      PW = $urandom();
      k  = $urandom_range(0, 9);
      save    = (k < 3) || (k == 9);
      restore = (k >= 3 && k < 6) || (k == 9);
      WIM = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, N - 1)) : 8'h00;
      RA = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
      RB = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
      RD = 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rnd%0d PA r%0d", n, RA), PA, m_port(int'(RA)));
      check($sformatf("rnd%0d PB r%0d", n, RB), PB, m_port(int'(RB)));
      check($sformatf("rnd%0d PD r%0d", n, RD), PD, m_port(int'(RD)));
      m_step();
      tick();
      check($sformatf("rnd%0d cwp", n), 32'(cwp), 32'(m_cwp));
      check($sformatf("rnd%0d trap_ovf", n), 32'(trap_ovf), 32'(m_ovf));
      check($sformatf("rnd%0d trap_unf", n), 32'(trap_unf), 32'(m_unf));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
